rs_encoder_256: RTL and testbench
=================================

Name: rs_encoder_256

Overview:
- Byte-serial systematic Reed-Solomon encoder over GF(256), primitive polynomial 0x11D, alpha = 0x02.
- Produces the codewords whose 16 syndromes are consumed by the decoder-side BerlekampMassey block. It is the transmit end of the same RS(255,239) t=8 link.
- Accepts MSG_LEN message bytes and passes them through unchanged. It then appends 16 parity bytes computed by an LFSR division by g(x).
- g(x) = product over i=0..15 of (x + alpha^i), which gives first consecutive root alpha^0 and matches the syndrome convention S_j = c(alpha^j), j=0..15.

Parameters:
- MSG_LEN, 239: message bytes per codeword. Legal range 1..239 (values below 239 give a shortened code).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  8  message byte; first byte is the highest-degree coefficient.
- din_valid  input  1  din holds a valid byte.
- din_ready  output  1  encoder accepts din this cycle.
- dout  output  8  codeword byte (message, then parity).
- dout_valid  output  1  dout holds a valid byte.
- dout_last  output  1  marks the final parity byte of a codeword.
- dout_ready  input  1  downstream accepts dout this cycle.
- busy  output  1  high from the first accepted byte until the last parity byte is accepted.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - state = DATA, byte counter = 0, parity registers R[0..15] = 0.
  - dout = 0, dout_valid = 0, dout_last = 0, busy = 0.
  - din_ready is combinational, so it is 1 after reset provided the output slot is free.
- Output slot: free when (!dout_valid || dout_ready). All output is registered; at most one byte sits in flight.
- Handshake: a transfer happens on a rising edge where valid and ready are both high. dout, dout_valid and dout_last hold stable while dout_valid=1 and dout_ready=0.
- State machine:
  - DATA: din_ready = slot free. On accept:
    - dout <= din, dout_valid <= 1, counter++.
    - f = din ^ R[15]; R[i] <= R[i-1] ^ (g_i * f) for i=1..15; R[0] <= g_0 * f. Here g_i is a coefficient of g(x) and g_16 = 1 is implicit.
    - g_i are hard-coded constants. Multiplies use the existing gf256_mul.
    - When the accepted byte is number MSG_LEN, go to PARITY with counter = 0.
  - Idle slots in DATA: if the slot is free and no accept occurs, dout_valid <= 0.
  - PARITY: din_ready = 0. On each free slot:
    - dout <= R[15], dout_valid <= 1; shift R[i] <= R[i-1], R[0] <= 0; counter++.
    - For the 16th parity byte, dout_last <= 1, R is cleared, counter <= 0, and the next state is DATA.
  - Consecutive codewords: a back-to-back codeword may start on the cycle after the last parity byte is loaded. No idle gap is required.
- Output order: message bytes m[MSG_LEN-1]..m[0], then parity p15..p0, where c(x) = m(x)*x^16 + (m(x)*x^16 mod g(x)).
- Codeword length: MSG_LEN+16 bytes on dout per codeword.
- busy:
  - Goes to 1 on the first accepted message byte.
  - Goes to 0 on the edge where the dout_last byte is accepted downstream.
- Counter: 8 bits wide. The count never wraps within a codeword because MSG_LEN ≤ 239.
- din_valid while in PARITY: ignored; the byte is not consumed. The upstream source holds it.
- Reset mid-codeword: every register returns to its reset value immediately and any partial codeword is discarded. Downstream must treat dout_valid dropping without dout_last as an aborted frame.
- Throughput: one byte per cycle when dout_ready=1 continuously, giving MSG_LEN+16 cycles per codeword.

Test Plan:
- All-zero message, MSG_LEN=239, dout_ready=1 constant:
  - Expect 239 zero bytes followed by 16 zero parity bytes.
  - dout_last high only on output byte 255. busy is high for 255 cycles.
- Message of 238 zeros then 0x01 (m(x)=1):
  - Expect parity bytes = g_15..g_0, i.e. the generator coefficients.
  - Check against a software product of (x+alpha^i), i=0..15, over 0x11D.
- Random message:
  - Compute the 16 syndromes of the output codeword at alpha^0..alpha^15; all must be 0x00.
  - Corrupt 8 bytes, feed the syndromes into BerlekampMassey, and check that its L equals 8.
- Backpressure:
  - Random message; hold dout_ready=0 for 5 cycles at message byte 100 and again at parity byte 3.
  - Output sequence must be identical to the stall-free run.
  - dout must be stable during each stall, and din_ready=0 while stalled.
- Back-to-back frames, MSG_LEN=4:
  - Send bytes 0x01,0x02,0x03,0x04 then 0x05..0x08 with din_valid held high.
  - Expect two 20-byte codewords with no gap, each parity matching the software model.
  - Expect no din acceptance during the parity phases.
- Reset mid-operation:
  - Assert rst_n=0 after message byte 50.
  - All outputs must be 0 in the same cycle (asynchronous).
  - The next frame after release must encode correctly, with no residue from the aborted frame in R.

Source files
------------

// File: rtl/rs_encoder_256.sv
// Byte-serial systematic Reed-Solomon encoder over GF(256), field polynomial 0x11D.
// Message bytes pass straight through; 16 parity bytes follow from an LFSR division by g(x).
module rs_encoder_256 #(
  parameter int MSG_LEN = 239
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       dout_last,
  input  logic       dout_ready,
  output logic       busy
);

  typedef enum logic [0:0] {ST_DATA = 1'b0, ST_PARITY = 1'b1} state_e;

  function automatic logic [7:0] gf256_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int k = 0; k < 8; k++) begin
      acc = b[k] ? (acc ^ sh) : acc;
      sh  = sh[7] ? ({sh[6:0], 1'b0} ^ 8'h1D) : {sh[6:0], 1'b0};
    end
    return acc;
  endfunction

  // Expands prod (x + alpha^i), i=0..15, at elaboration; returns g_0..g_15 (g_16 = 1 is implicit).
  function automatic logic [127:0] gen_poly();
    logic [135:0] c;
    logic [7:0]   root;
    c    = 136'd1;
    root = 8'h01;
    for (int i = 0; i < 16; i++) begin
      for (int j = 16; j >= 1; j--) begin
        c[8*j +: 8] = c[8*(j-1) +: 8] ^ gf256_mul(c[8*j +: 8], root);
      end
      c[7:0] = gf256_mul(c[7:0], root);
      root   = gf256_mul(root, 8'h02);
    end
    return c[127:0];
  endfunction

  localparam logic [127:0] GEN      = gen_poly();
  localparam logic [7:0]   LAST_MSG = 8'(MSG_LEN - 1);
  localparam logic [7:0]   LAST_PAR = 8'd15;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] par_q [16];
  logic [7:0] par_d [16];
  logic [7:0] dout_q, dout_d;
  logic       dout_valid_q, dout_valid_d;
  logic       dout_last_q, dout_last_d;
  logic       busy_q, busy_d;
  logic       slot_free_s;
  logic       accept_s;
  logic [7:0] fb_s;

  assign slot_free_s = !dout_valid_q || dout_ready;
  assign din_ready   = (state_q == ST_DATA) && slot_free_s;
  assign accept_s    = din_valid && din_ready;
  assign fb_s        = din ^ par_q[15];

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign busy       = busy_q;

  // Next-state: message pass-through with LFSR update, then parity shift-out.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    par_d        = par_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    if (dout_valid_q && dout_last_q && dout_ready) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_q;
    end

    case (state_q)
      ST_DATA: begin
        if (accept_s) begin
          dout_d       = din;
          dout_valid_d = 1'b1;
          dout_last_d  = 1'b0;
          busy_d       = 1'b1;
          par_d[0]     = gf256_mul(GEN[7:0], fb_s);
          for (int i = 1; i < 16; i++) begin
            par_d[i] = par_q[i-1] ^ gf256_mul(GEN[8*i +: 8], fb_s);
          end
          if (cnt_q == LAST_MSG) begin
            state_d = ST_PARITY;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else if (slot_free_s) begin
          dout_valid_d = 1'b0;
          dout_last_d  = 1'b0;
        end else begin
          dout_valid_d = dout_valid_q;
        end
      end
      ST_PARITY: begin
        if (slot_free_s) begin
          dout_d       = par_q[15];
          dout_valid_d = 1'b1;
          if (cnt_q == LAST_PAR) begin
            dout_last_d = 1'b1;
            cnt_d       = 8'd0;
            state_d     = ST_DATA;
            for (int i = 0; i < 16; i++) begin
              par_d[i] = 8'h00;
            end
          end else begin
            dout_last_d = 1'b0;
            cnt_d       = cnt_q + 8'd1;
            par_d[0]    = 8'h00;
            for (int i = 1; i < 16; i++) begin
              par_d[i] = par_q[i-1];
            end
          end
        end else begin
          dout_valid_d = dout_valid_q;
        end
      end
      default: begin
        state_d = ST_DATA;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State, parity and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_DATA;
      cnt_q        <= 8'd0;
      dout_q       <= 8'h00;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        par_q[i] <= 8'h00;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      busy_q       <= busy_d;
      par_q        <= par_d;
    end
  end

endmodule

// File: tb/tb_rs_encoder_256.sv
// Directed bench for rs_encoder_256: reference long-division encoder, syndromes,
// Berlekamp-Massey length, backpressure, asynchronous abort and back-to-back frames.
module tb_rs_encoder_256;
  localparam int N = 239;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din, dout, din4, dout4;
  logic       din_valid, din_ready, dout_valid, dout_last, dout_ready, busy;
  logic       din4_valid, din4_ready, dout4_valid, dout4_last, dout4_ready, busy4;

  always #5 clk = ~clk;

  rs_encoder_256 #(.MSG_LEN(N)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last), .dout_ready(dout_ready), .busy(busy));

  rs_encoder_256 #(.MSG_LEN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .din(din4), .din_valid(din4_valid), .din_ready(din4_ready),
    .dout(dout4), .dout_valid(dout4_valid), .dout_last(dout4_last), .dout_ready(dout4_ready), .busy(busy4));

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] exp_t [255];
  int         log_t [256];
  logic [7:0] gh [17];
  logic [7:0] msg [N];
  logic [7:0] ref_cw [N+16];
  logic [7:0] cw [N+16];
  logic [7:0] synd_s [16];
  logic [7:0] got [$];
  logic [7:0] saved [$];
  int last_idx, last_cnt, busy_cyc, stall_bad, stall_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return exp_t[(log_t[a] + log_t[b]) % 255];
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    return exp_t[(255 - log_t[a]) % 255];
  endfunction

  task automatic init_tables();
    logic [8:0] e;
    e = 9'd1;
    log_t[0] = 0;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = e[7:0];
      log_t[e[7:0]] = i;
      e = e << 1;
      if (e[8]) e = e ^ 9'h11D;
    end
    // generator kept high-degree first: gh[0] = 1 is the x^16 coefficient
    for (int k = 0; k < 17; k++) gh[k] = 8'h00;
    gh[0] = 8'h01;
    for (int i = 0; i < 16; i++)
      for (int k = i + 1; k >= 1; k--) gh[k] = gh[k] ^ gmul(exp_t[i], gh[k-1]);
  endtask

  // Reference codeword by plain polynomial long division of m(x)*x^16 by g(x).
  task automatic encode(input int len);
    logic [7:0] w [N+16];
    logic [7:0] coef;
    for (int k = 0; k < len + 16; k++) w[k] = (k < len) ? msg[k] : 8'h00;
    for (int i = 0; i < len; i++) begin
      coef = w[i];
      for (int j = 1; j <= 16; j++) w[i+j] = w[i+j] ^ gmul(coef, gh[j]);
    end
    for (int k = 0; k < len + 16; k++) ref_cw[k] = (k < len) ? msg[k] : w[k];
  endtask

  task automatic copy_got(input int n);
    for (int k = 0; k < n; k++) cw[k] = (k < got.size()) ? got[k] : 8'h00;
  endtask

  function automatic int mism_ref(input int n);
    int e = 0;
    for (int k = 0; k < n; k++) if (cw[k] !== ref_cw[k]) e++;
    return e;
  endfunction

  task automatic calc_synd(input int n);
    logic [7:0] s;
    for (int j = 0; j < 16; j++) begin
      s = 8'h00;
      for (int k = 0; k < n; k++) s = gmul(s, exp_t[j]) ^ cw[k];
      synd_s[j] = s;
    end
  endtask

  function automatic int nz_synd();
    int c = 0;
    for (int j = 0; j < 16; j++) if (synd_s[j] != 8'h00) c++;
    return c;
  endfunction

  function automatic int bm_len();
    logic [7:0] C [17];
    logic [7:0] B [17];
    logic [7:0] T [17];
    logic [7:0] d, b, coef;
    int L, m;
    for (int i = 0; i < 17; i++) begin C[i] = 8'h00; B[i] = 8'h00; end
    C[0] = 8'h01; B[0] = 8'h01; L = 0; m = 1; b = 8'h01;
    for (int n = 0; n < 16; n++) begin
      d = synd_s[n];
      for (int i = 1; i <= L; i++) d = d ^ gmul(C[i], synd_s[n-i]);
      if (d == 8'h00) begin
        m++;
      end else begin
        coef = gmul(d, ginv(b));
        T = C;
        for (int i = 0; i + m <= 16; i++) C[i+m] = C[i+m] ^ gmul(coef, B[i]);
        if (2 * L <= n) begin
          L = n + 1 - L; B = T; b = d; m = 1;
        end else begin
          m++;
        end
      end
    end
    return L;
  endfunction

  // Feeds msg into the main DUT and collects its output; called #1 after a rising edge.
  task automatic run_frame(input int stall_a, input int stall_b, input int abort_at);
    int in_idx = 0;
    int stall_left = 0;
    logic sa_done = 1'b0;
    logic sb_done = 1'b0;
    logic done = 1'b0;
    logic [7:0] held = 8'h00;
    got.delete();
    last_idx = -1; last_cnt = 0; busy_cyc = 0; stall_bad = 0; stall_seen = 0;
    din = msg[0]; din_valid = 1'b1; dout_ready = 1'b1;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (dout_last) last_cnt++;
      if (!dout_ready) begin
        stall_seen++;
        if (dout !== held || dout_valid !== 1'b1 || din_ready !== 1'b0) stall_bad++;
      end
      if (dout_valid && dout_ready) begin
        got.push_back(dout);
        if (dout_last) begin last_idx = got.size() - 1; done = 1'b1; end
      end
      if (din_valid && din_ready) in_idx++;
      @(posedge clk); #1;
      if (abort_at > 0 && in_idx == abort_at && !done) begin
        rst_n = 1'b0;
        #1;
        check("abort_dout", dout, 8'h00);
        check("abort_dout_valid", dout_valid, 1'b0);
        check("abort_dout_last", dout_last, 1'b0);
        check("abort_busy", busy, 1'b0);
        din_valid = 1'b0;
        done = 1'b1;
      end else begin
        if (in_idx < N) din = msg[in_idx];
        else begin din_valid = 1'b0; din = 8'h00; end
        if (stall_left > 0) begin
          stall_left--;
          if (stall_left == 0) dout_ready = 1'b1;
        end else if (!sa_done && got.size() == stall_a && dout_valid) begin
          sa_done = 1'b1; stall_left = 5; dout_ready = 1'b0; held = dout;
        end else if (!sb_done && got.size() == stall_b && dout_valid) begin
          sb_done = 1'b1; stall_left = 5; dout_ready = 1'b0; held = dout;
        end
      end
    end
    check("frame_completed", done, 1'b1);
    din_valid = 1'b0;
    dout_ready = 1'b1;
  endtask

  logic [7:0] got4 [$];
  logic       lst4 [$];
  int         tcyc [$];
  int         acc [$];
  logic [7:0] ref4 [40];
  int         k4, e4, nl4;

  initial begin
    init_tables();
    rst_n = 1'b0; din = 8'h00; din_valid = 1'b0; dout_ready = 1'b1;
    din4 = 8'h00; din4_valid = 1'b0; dout4_ready = 1'b1;
    #12;
    check("rst_dout", dout, 8'h00);
    check("rst_dout_valid", dout_valid, 1'b0);
    check("rst_dout_last", dout_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_din_ready", din_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // all-zero message
    for (int k = 0; k < N; k++) msg[k] = 8'h00;
    encode(N);
    run_frame(-1, -1, 0);
    copy_got(N + 16);
    check("zero_len", got.size(), 32'd255);
    check("zero_bytes", mism_ref(N + 16), 32'd0);
    check("zero_last_idx", last_idx, 32'd254);
    check("zero_last_cnt", last_cnt, 32'd1);
    check("zero_busy_cycles", busy_cyc, 32'd255);
    @(posedge clk); #1;
    check("zero_busy_end", busy, 1'b0);
    check("zero_valid_end", dout_valid, 1'b0);

    // m(x) = 1: parity equals the generator coefficients g_15..g_0
    msg[N-1] = 8'h01;
    run_frame(-1, -1, 0);
    copy_got(N + 16);
    for (int k = 0; k < 16; k++) check($sformatf("gen_p%0d", 15 - k), cw[N+k], gh[k+1]);
    calc_synd(N + 16);
    check("gen_syndromes", nz_synd(), 32'd0);
    @(posedge clk); #1;

    // random message
    for (int k = 0; k < N; k++) msg[k] = 8'($urandom_range(0, 255));
    encode(N);
    run_frame(-1, -1, 0);
    copy_got(N + 16);
    check("rand_len", got.size(), 32'd255);
    check("rand_bytes", mism_ref(N + 16), 32'd0);
    calc_synd(N + 16);
    check("rand_syndromes", nz_synd(), 32'd0);
    saved = got;
    cw[3] ^= 8'h11;   cw[40] ^= 8'h5A;  cw[77] ^= 8'h01;  cw[100] ^= 8'hC3;
    cw[150] ^= 8'h80; cw[201] ^= 8'h2E; cw[230] ^= 8'hFF; cw[250] ^= 8'h07;
    calc_synd(N + 16);
    check("bm_L_8_errors", bm_len(), 32'd8);
    @(posedge clk); #1;

    // same message with two 5-cycle stalls
    run_frame(100, N + 3, 0);
    check("bp_len", got.size(), 32'd255);
    e4 = 0;
    for (int k = 0; k < 255; k++) if (k >= got.size() || got[k] !== saved[k]) e4++;
    check("bp_bytes", e4, 32'd0);
    check("bp_stall_cycles", stall_seen, 32'd10);
    check("bp_stall_stable", stall_bad, 32'd0);
    check("bp_busy_cycles", busy_cyc, 32'd265);
    @(posedge clk); #1;

    // abort after 50 message bytes, then a clean frame
    for (int k = 0; k < N; k++) msg[k] = 8'($urandom_range(0, 255));
    run_frame(-1, -1, 50);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_abort_idle", dout_valid, 1'b0);
    for (int k = 0; k < N; k++) msg[k] = 8'($urandom_range(0, 255));
    encode(N);
    run_frame(-1, -1, 0);
    copy_got(N + 16);
    check("post_abort_len", got.size(), 32'd255);
    check("post_abort_bytes", mism_ref(N + 16), 32'd0);
    @(posedge clk); #1;

    // back-to-back frames on the MSG_LEN=4 instance
    for (int k = 0; k < 4; k++) msg[k] = 8'(k + 1);
    encode(4);
    for (int k = 0; k < 20; k++) ref4[k] = ref_cw[k];
    for (int k = 0; k < 4; k++) msg[k] = 8'(k + 5);
    encode(4);
    for (int k = 0; k < 20; k++) ref4[20+k] = ref_cw[k];
    din4 = 8'h01; din4_valid = 1'b1; dout4_ready = 1'b1; k4 = 0;
    for (int cyc = 0; cyc < 100 && got4.size() < 40; cyc++) begin
      @(negedge clk);
      if (dout4_valid && dout4_ready) begin
        got4.push_back(dout4); lst4.push_back(dout4_last); tcyc.push_back(cyc);
      end
      if (din4_valid && din4_ready) begin acc.push_back(cyc); k4++; end
      @(posedge clk); #1;
      if (k4 < 8) din4 = 8'(k4 + 1);
      else din4_valid = 1'b0;
    end
    check("b2b_len", got4.size(), 32'd40);
    check("b2b_accepts", acc.size(), 32'd8);
    while (got4.size() < 40) begin got4.push_back(8'h00); lst4.push_back(1'b0); tcyc.push_back(-1); end
    while (acc.size() < 8) acc.push_back(-1);
    e4 = 0; nl4 = 0;
    for (int k = 0; k < 40; k++) begin
      if (got4[k] !== ref4[k]) e4++;
      if (lst4[k] === 1'b1) nl4++;
    end
    check("b2b_bytes", e4, 32'd0);
    check("b2b_last_count", nl4, 32'd2);
    check("b2b_last_frame1", lst4[19], 1'b1);
    check("b2b_last_frame2", lst4[39], 1'b1);
    check("b2b_accept_byte4", acc[3], 32'd3);
    check("b2b_accept_byte5", acc[4], 32'd20);
    check("b2b_no_gap", tcyc[39] - tcyc[0], 32'd39);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
